tdc_spi_arbiter: RTL and testbench
==================================

# tdc_spi_arbiter

Round-robin arbiter that shares the single TDC SPI master between up to `NUM_REQ` sequencers: per-channel measurement controllers, the init/soft-reset sequencer, and the debug register port. Each requester holds the bus for a whole multi-byte, CS-framed burst. Its start, MOSI and CS_END strobes are muxed to the SPI master. Non-granted requesters see a permanently busy SPI, which stalls their `!busy && !start` handshake. Sits between the requester FSMs and the SPI master.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WDOG_CYCLES`, default 4096: maximum cycles a grant may be held with no `spi_start` issued. Used only with `TDC_ARB_WDOG_EN`.
- `clk` in, 1: clock.
- `rst` in, 1: reset, synchronous, active-high.
- `req_lock` in, `NUM_REQ`: requester i wants the bus. Held high for the whole burst.
- `req_start` in, `NUM_REQ`: per-requester SPI start pulse.
- `req_mosi` in, `8*NUM_REQ`: byte i is at `[8*i+7:8*i]`.
- `req_cs_end` in, `NUM_REQ`: per-requester CS_END level.
- `grant` out, `NUM_REQ`: one-hot or zero. Bit i means requester i owns the SPI.
- `req_busy` out, `NUM_REQ`: busy as seen by each requester.
- `req_miso` out, 8: `spi_miso` broadcast to all requesters.
- `spi_start` out, 1: start to the SPI master.
- `spi_mosi` out, 8: data to the SPI master.
- `spi_cs_end` out, 1: CS_END to the SPI master.
- `spi_busy` in, 1: SPI master busy.
- `spi_miso` in, 8: SPI master received byte.
- `wdog_err` out, 1: one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- States: IDLE, GRANT, DRAIN.
- IDLE
  - `grant`=0.
  - If any `req_lock` is set, pick the first set bit scanning from `last+1` modulo `NUM_REQ`, where `last` is the index of the previous winner.
  - Register `grant` one-hot, update `last`, go to GRANT.
  - After reset `last`=`NUM_REQ-1`, so requester 0 wins first.
- GRANT
  - `spi_start`, `spi_mosi`, `spi_cs_end` are registered copies of the granted requester's inputs.
  - `req_busy[g]` = `spi_busy` | `spi_start`, where `spi_start` is the registered output. This covers the cycle before the master asserts busy.
  - When `req_lock[g]` falls, go to DRAIN.
  - Inputs from non-granted requesters are ignored. Their `req_start` pulses are dropped, not queued.
- DRAIN
  - Hold `grant` until `spi_busy`=0 and `spi_start`=0, so the in-flight byte completes.
  - Then `grant`=0 and go to IDLE.
  - A new grant is therefore never issued in the same cycle as a release.
- Non-granted `req_busy` bits are always 1. In IDLE all `req_busy` bits are 1.
- `spi_cs_end` holds its last granted value after release. With no grant yet since reset it is 1, meaning CS deasserted.
- `req_lock[g]` re-raised in DRAIN is treated as a new request. It wins only after round-robin rotation.
- `req_lock` dropping in the same cycle a grant is issued: enter GRANT, then DRAIN on the next cycle. No `spi_start` is forwarded.

## Timing
- Reset values:
  - state=IDLE, `grant`=0, `req_busy`=all 1, `req_miso`=0.
  - `spi_start`=0, `spi_mosi`=0, `spi_cs_end`=1, `wdog_err`=0, `last`=`NUM_REQ-1`.
- Arbitration latency: `req_lock` high at cycle n gives `grant` at n+1. This assumes IDLE and no higher-priority contender.
- Request path latency: `req_start[g]` at cycle n gives `spi_start` at n+1, with `spi_mosi` valid the same cycle.
- `req_miso` = `spi_miso` registered, 1 cycle of latency.
- Release: the cycle after `spi_busy` and `spi_start` are both 0 in DRAIN, `grant` goes to 0. The earliest next grant is 1 cycle later.
- `rst` mid-burst: all outputs return to reset values on the next edge, and `spi_start` is never left high. SPI master recovery is handled outside this block.

## Configuration
- `TDC_ARB_WDOG_EN` defined:
  - In GRANT a counter increments each cycle without `spi_start` and clears on `spi_start`.
  - When it reaches `WDOG_CYCLES`, go to DRAIN, pulse `wdog_err`, and drive `spi_cs_end`=1.
  - The offending requester is not re-granted until its `req_lock` has been seen low.
- `TDC_ARB_WDOG_EN` undefined:
  - No counter.
  - `wdog_err` is tied to 0.
  - A grant is held indefinitely.

## Test plan
- Single requester:
  - Stimulus: `req_lock[0]`=1, then 4 starts with bytes 0x81, 0x00, 0x00, 0x00, `spi_busy` 8 cycles each.
  - Required response: `grant`=0001 one cycle later, 4 `spi_start` pulses with matching `spi_mosi`, DRAIN/release after the last byte.
- Contention:
  - Stimulus: `req_lock`=1111 held continuously with 2-byte bursts.
  - Required response: grant order 0, 1, 2, 3, 0, with no overlap and at least 1 cycle of `grant`=0 between owners.
- Stalled requester:
  - Stimulus: requester 2 pulses `req_start` while requester 1 is granted.
  - Required response: no `spi_start`, and `req_busy[2]`=1 throughout.
- Mid-byte unlock:
  - Stimulus: `req_lock[g]` falls while `spi_busy`=1.
  - Required response: `grant` is held until busy falls, then released the next cycle.
- Reset mid-burst:
  - Stimulus: `rst` during GRANT with `spi_start`=1.
  - Required response: next cycle `spi_start`=0, `grant`=0, `spi_cs_end`=1; the next grant after reset goes to requester 0.
- Watchdog (`TDC_ARB_WDOG_EN`, `WDOG_CYCLES`=16):
  - Stimulus: requester granted with no starts for 16 cycles.
  - Required response: `wdog_err` pulses once and release follows; the requester is not re-granted until its lock has toggled.

Source files
------------

// File: rtl/tdc_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tdc_spi_arbiter
//  Description : Round-robin arbiter sharing one TDC SPI master between
//                NUM_REQ burst-oriented requesters. The owner's start, MOSI
//                and CS_END are registered through to the master; every other
//                requester sees a permanently busy SPI.
//                Optional grant watchdog: define TDC_ARB_WDOG_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tdc_spi_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_lock,
    input  logic [NUM_REQ-1:0]     req_start,
    input  logic [8*NUM_REQ-1:0]   req_mosi,
    input  logic [NUM_REQ-1:0]     req_cs_end,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     req_busy,
    output logic [7:0]             req_miso,
    output logic                   spi_start,
    output logic [7:0]             spi_mosi,
    output logic                   spi_cs_end,
    input  logic                   spi_busy,
    input  logic [7:0]             spi_miso,
    output logic                   wdog_err
);

    localparam int                c_idx_w    = $clog2(NUM_REQ);
    localparam logic [c_idx_w:0]  c_num      = (c_idx_w+1)'(NUM_REQ);
    localparam logic [c_idx_w-1:0] c_last_rst = c_idx_w'(NUM_REQ - 1);

    // Elaboration-time guard on the supported parameter range.
    if (NUM_REQ < 2 || NUM_REQ > 8 || WDOG_CYCLES < 2) begin : g_param_check
        $error("tdc_spi_arbiter: NUM_REQ must be 2..8 and WDOG_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [c_idx_w-1:0]   r_last;        // previous winner; also the current owner while granted
    logic                 r_spi_start;
    logic [7:0]           r_spi_mosi;
    logic                 r_spi_cs_end;
    logic [7:0]           r_req_miso;

    logic [NUM_REQ-1:0]   w_req_eff;     // requests eligible for arbitration
    logic                 w_any;
    logic [c_idx_w-1:0]   w_win_idx;
    logic [c_idx_w:0]     w_sum;
    logic                 w_trip;        // watchdog revokes the grant this cycle
    logic                 w_lock_g;
    logic                 w_start_g;
    logic                 w_cs_g;
    logic [7:0]           w_mosi_g;
    logic                 w_release;

    assign grant      = r_grant;
    assign spi_start  = r_spi_start;
    assign spi_mosi   = r_spi_mosi;
    assign spi_cs_end = r_spi_cs_end;
    assign req_miso   = r_req_miso;
    assign w_release  = !spi_busy && !r_spi_start;

    // Select the owner's request signals (owner index is r_last).
    always_comb begin
        w_lock_g  = 1'b0;
        w_start_g = 1'b0;
        w_cs_g    = 1'b1;
        w_mosi_g  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_last == c_idx_w'(i)) begin
                w_lock_g  = req_lock[i];
                w_start_g = req_start[i];
                w_cs_g    = req_cs_end[i];
                w_mosi_g  = req_mosi[8*i +: 8];
            end
        end
    end

    // Round-robin search from r_last+1; scanning offsets downwards lets the
    // nearest requester overwrite farther ones.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = r_last;
        w_sum     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_sum = {1'b0, r_last} + (c_idx_w+1)'(k);
            if (w_sum >= c_num) begin
                w_sum = w_sum - c_num;
            end
            if (w_req_eff[w_sum[c_idx_w-1:0]]) begin
                w_any     = 1'b1;
                w_win_idx = w_sum[c_idx_w-1:0];
            end
        end
    end

    // Busy seen by each requester: only the owner sees the real master.
    always_comb begin
        req_busy = '1;
        if (r_state != S_IDLE) begin
            req_busy[r_last] = spi_busy | r_spi_start;
        end
    end

`ifdef TDC_ARB_WDOG_EN
    localparam int                   c_wcnt_w   = $clog2(WDOG_CYCLES);
    localparam logic [c_wcnt_w-1:0]  c_wdog_max = c_wcnt_w'(WDOG_CYCLES - 1);

    logic [c_wcnt_w-1:0] r_wdog_cnt;
    logic [NUM_REQ-1:0]  r_blocked;     // requesters revoked by the watchdog, awaiting lock low
    logic                r_wdog_err;

    assign w_trip    = (r_state == S_GRANT) && w_lock_g && !r_spi_start &&
                       (r_wdog_cnt == c_wdog_max);
    assign w_req_eff = req_lock & ~r_blocked;
    assign wdog_err  = r_wdog_err;

    // Count granted cycles without a start; remember revoked owners.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog_cnt <= '0;
            r_blocked  <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_err <= w_trip;
            if (r_state != S_GRANT || r_spi_start || w_trip) begin
                r_wdog_cnt <= '0;
            end else begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end
            r_blocked <= (r_blocked & req_lock) | (w_trip ? r_grant : '0);
        end
    end
`else
    assign w_trip    = 1'b0;
    assign w_req_eff = req_lock;
    assign wdog_err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!w_lock_g || w_trip) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Grant bookkeeping and the registered request path to the SPI master.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= '0;
            r_last       <= c_last_rst;
            r_spi_start  <= 1'b0;
            r_spi_mosi   <= '0;
            r_spi_cs_end <= 1'b1;
            r_req_miso   <= '0;
        end else begin
            r_req_miso  <= spi_miso;
            r_spi_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win_idx;
                        r_last  <= w_win_idx;
                    end
                end
                S_GRANT: begin
                    if (w_trip) begin
                        r_spi_cs_end <= 1'b1;       // force CS off on a revoked burst
                    end else if (w_lock_g) begin
                        r_spi_start  <= w_start_g;
                        r_spi_mosi   <= w_mosi_g;
                        r_spi_cs_end <= w_cs_g;
                    end
                end
                S_DRAIN: begin
                    if (w_release) begin
                        r_grant <= '0;
                    end
                end
                default: r_grant <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tdc_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tdc_spi_arbiter
//  Description : Self-checking bench for tdc_spi_arbiter with an owner-level
//                reference model checked every cycle, plus directed literal
//                checks. Watchdog scenario runs when TDC_ARB_WDOG_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tdc_spi_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_lock   = '0;
    logic [N-1:0]   req_start  = '0;
    logic [8*N-1:0] req_mosi   = '0;
    logic [N-1:0]   req_cs_end = '1;
    logic [N-1:0]   grant;
    logic [N-1:0]   req_busy;
    logic [7:0]     req_miso;
    logic           spi_start;
    logic [7:0]     spi_mosi;
    logic           spi_cs_end;
    logic           spi_busy = 1'b0;
    logic [7:0]     spi_miso = 8'h00;
    logic           wdog_err;

    int n_checks = 0;
    int n_errors = 0;

    tdc_spi_arbiter #(.NUM_REQ(N), .WDOG_CYCLES(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_lock   (req_lock),
        .req_start  (req_start),
        .req_mosi   (req_mosi),
        .req_cs_end (req_cs_end),
        .grant      (grant),
        .req_busy   (req_busy),
        .req_miso   (req_miso),
        .spi_start  (spi_start),
        .spi_mosi   (spi_mosi),
        .spi_cs_end (spi_cs_end),
        .spi_busy   (spi_busy),
        .spi_miso   (spi_miso),
        .wdog_err   (wdog_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: who owns the bus, what is forwarded
    int           m_owner = -1;   // -1: nobody owns the SPI
    bit           m_held  = 0;    // owner still holds its lock (not yet releasing)
    int           m_last  = N-1;
    logic         m_start = 1'b0;
    logic [7:0]   m_mosi  = 8'h00;
    logic         m_cs    = 1'b1;
    logic [7:0]   m_miso  = 8'h00;
    logic         m_wdog  = 1'b0;
    int           m_idle_run = 0; // consecutive owned cycles without a start
    logic [N-1:0] m_blk   = '0;
    bit           m_valid = 0;

    always @(posedge clk) begin : p_model
        int   o;
        bit   trip;
        logic prev_start;
        if (rst) begin
            m_owner = -1; m_held = 0; m_last = N-1; m_start = 1'b0; m_mosi = 8'h00;
            m_cs = 1'b1; m_miso = 8'h00; m_wdog = 1'b0; m_idle_run = 0; m_blk = '0;
            m_valid = 1;
        end else begin
            prev_start = m_start;
            m_miso  = spi_miso;
            m_wdog  = 1'b0;
            m_start = 1'b0;
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    o = (m_last + k) % N;
                    if (req_lock[o] && !m_blk[o]) begin
                        m_owner = o; m_last = o; m_held = 1; m_idle_run = 0;
                        break;
                    end
                end
            end else if (m_held) begin
                if (!req_lock[m_owner]) begin
                    m_held = 0;
                end else begin
                    trip = 0;
`ifdef TDC_ARB_WDOG_EN
                    if (prev_start) m_idle_run = 0;
                    else begin
                        m_idle_run++;
                        if (m_idle_run == W) trip = 1;
                    end
`endif
                    if (trip) begin
                        m_held = 0; m_cs = 1'b1; m_wdog = 1'b1; m_blk[m_owner] = 1'b1;
                    end else begin
                        m_start = req_start[m_owner];
                        m_mosi  = req_mosi[8*m_owner +: 8];
                        m_cs    = req_cs_end[m_owner];
                    end
                end
            end else begin
                if (!spi_busy && !prev_start) m_owner = -1;
            end
            for (int i = 0; i < N; i++) if (!req_lock[i]) m_blk[i] = 1'b0;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin : p_compare
        logic [N-1:0] eg;
        logic [N-1:0] eb;
        if (m_valid) begin
            eg = '0;
            eb = '1;
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                eb[m_owner] = spi_busy | m_start;
            end
            check("m_grant",      grant,      eg);
            check("m_req_busy",   req_busy,   eb);
            check("m_spi_start",  spi_start,  m_start);
            check("m_spi_mosi",   spi_mosi,   m_mosi);
            check("m_spi_cs_end", spi_cs_end, m_cs);
            check("m_req_miso",   req_miso,   m_miso);
            check("m_wdog_err",   wdog_err,   m_wdog);
        end
    end

    // ---------------- stimulus helpers
    task automatic step();
        @(posedge clk);
        #1;
        spi_miso = 8'($urandom);
    endtask

    task automatic send_byte(input int r, input logic [7:0] b, input logic cs);
        req_start[r] = 1'b1;
        req_mosi[8*r +: 8] = b;
        req_cs_end[r] = cs;
        step();
        req_start[r] = 1'b0;
        check("byte_start", spi_start, 1'b1);
        check("byte_mosi",  spi_mosi,  b);
        step();
        spi_busy = 1'b1;
        repeat (8) step();
        spi_busy = 1'b0;
        step();
    endtask

    task automatic wait_grant(output int g);
        g = -1;
        for (int t = 0; t < 50 && grant == '0; t++) step();
        check("wait_grant_timeout", (grant != '0), 1'b1);
        for (int i = 0; i < N; i++) if (grant[i]) g = i;
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 50 && grant != '0; t++) step();
        check("wait_idle_timeout", (grant == '0), 1'b1);
    endtask

    initial begin : p_timeout
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : p_stim
        int g;
        int order[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int pulses;

        // Reset values
        repeat (3) step();
        check("rst_grant",    grant,      4'b0000);
        check("rst_busy",     req_busy,   4'b1111);
        check("rst_start",    spi_start,  1'b0);
        check("rst_mosi",     spi_mosi,   8'h00);
        check("rst_cs_end",   spi_cs_end, 1'b1);
        check("rst_miso",     req_miso,   8'h00);
        check("rst_wdog",     wdog_err,   1'b0);
        rst = 1'b0;
        step();

        // Single requester: 1-cycle arbitration, 4-byte burst, release
        req_lock[0] = 1'b1;
        step();
        check("single_grant", grant, 4'b0001);
        send_byte(0, 8'h81, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h00, 1'b0);
        send_byte(0, 8'h00, 1'b1);
        req_lock[0] = 1'b0;
        wait_idle();

        // Contention from a fresh reset: rotation 0,1,2,3,0
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_lock = 4'b1111;
        for (int it = 0; it < 5; it++) begin
            wait_grant(g);
            order.push_back(g);
            if (g == 1) begin
                // Stalled requester 2 pulses start while 1 owns the bus
                req_start[2] = 1'b1;
                req_mosi[23:16] = 8'hEE;
                check("stall_busy2_a", req_busy[2], 1'b1);
                step();
                req_start[2] = 1'b0;
                check("stall_no_start", spi_start,   1'b0);
                check("stall_busy2_b",  req_busy[2], 1'b1);
            end
            send_byte(g, 8'(8'h10 + g), 1'b0);
            send_byte(g, 8'(8'h20 + g), 1'b1);
            req_lock[g] = 1'b0;
            step();
            req_lock[g] = 1'b1;
            wait_idle();
        end
        req_lock = 4'b0000;
        step();
        for (int i = 0; i < 5; i++) begin
            check("rr_order", (i < order.size()) ? order[i] : -1, exp_order[i]);
        end

        // Mid-byte unlock: grant held while busy, released the cycle after
        req_lock[2] = 1'b1;
        wait_grant(g);
        check("mid_owner", g, 2);
        req_start[2] = 1'b1;
        req_mosi[23:16] = 8'h5A;
        step();
        req_start[2] = 1'b0;
        step();
        spi_busy = 1'b1;
        step();
        req_lock[2] = 1'b0;
        repeat (4) begin
            step();
            check("mid_hold", grant, 4'b0100);
        end
        spi_busy = 1'b0;
        check("mid_hold_last", grant, 4'b0100);
        step();
        check("mid_release", grant, 4'b0000);
        step();

        // Reset mid-burst with spi_start high
        req_lock[3] = 1'b1;
        wait_grant(g);
        check("rst_owner", g, 3);
        req_cs_end[3] = 1'b0;
        req_mosi[31:24] = 8'hC3;
        req_start[3] = 1'b1;
        step();
        req_start[3] = 1'b0;
        check("rstb_start_hi", spi_start,  1'b1);
        check("rstb_cs_lo",    spi_cs_end, 1'b0);
        rst = 1'b1;
        step();
        check("rstb_start", spi_start,  1'b0);
        check("rstb_grant", grant,      4'b0000);
        check("rstb_cs",    spi_cs_end, 1'b1);
        rst = 1'b0;
        req_lock = 4'b1111;
        step();
        check("rstb_first", grant, 4'b0001);
        req_lock = 4'b0000;
        wait_idle();

        // Grant held with no starts
        req_lock[1] = 1'b1;
        wait_grant(g);
        check("wd_owner", g, 1);
`ifdef TDC_ARB_WDOG_EN
        pulses = 0;
        repeat (40) begin
            step();
            if (wdog_err) pulses++;
        end
        check("wd_pulses",  pulses, 1);
        check("wd_blocked", grant,  4'b0000);
        req_lock[1] = 1'b0;
        step();
        req_lock[1] = 1'b1;
        wait_grant(g);
        check("wd_regrant", g, 1);
`else
        pulses = 0;
        repeat (40) begin
            step();
            if (wdog_err) pulses++;
        end
        check("nowd_pulses", pulses, 0);
        check("nowd_held",   grant,  4'b0010);
`endif
        req_lock = 4'b0000;
        wait_idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
